// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback source handshakes and regfile write port
interface rf_wb_arbiter_if;
    logic        s0_valid;
    logic [4:0]  s0_rd;
    logic [31:0] s0_wdata;
    logic        s0_ready;
    logic        s1_valid;
    logic [4:0]  s1_rd;
    logic [31:0] s1_wdata;
    logic        s1_ready;
    logic        s2_valid;
    logic [4:0]  s2_rd;
    logic [31:0] s2_wdata;
    logic        s2_ready;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_wdata;

    modport master (
        output s0_valid, s0_rd, s0_wdata,
        output s1_valid, s1_rd, s1_wdata,
        output s2_valid, s2_rd, s2_wdata,
        input  s0_ready, s1_ready, s2_ready,
        input  rd, rd_we, rd_wdata
    );

    modport slave (
        input  s0_valid, s0_rd, s0_wdata,
        input  s1_valid, s1_rd, s1_wdata,
        input  s2_valid, s2_rd, s2_wdata,
        output s0_ready, s1_ready, s2_ready,
        output rd, rd_we, rd_wdata
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin regfile writeback arbiter with busy scoreboard
module rf_wb_arbiter (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave wb,
    input  logic           sb_set,
    input  logic [4:0]     sb_set_rd,
    input  logic [4:0]     q_rs1,
    input  logic [4:0]     q_rs2,
    output logic           busy_rs1,
    output logic           busy_rs2
);
    logic [2:0]  src_valid;
    logic [4:0]  src_rd    [3];
    logic [31:0] src_wdata [3];

    logic [1:0]  ptr_q, ptr_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_we_q, rd_we_d;
    logic [31:0] rd_wdata_q, rd_wdata_d;
    logic [31:0] busy_q, busy_d;

    logic [2:0]  grant;
    logic        gnt_any;
    logic [1:0]  gnt_idx;
    logic [2:0]  cand_sum;
    logic [1:0]  cand;

    assign src_valid    = {wb.s2_valid, wb.s1_valid, wb.s0_valid};
    assign src_rd[0]    = wb.s0_rd;
    assign src_rd[1]    = wb.s1_rd;
    assign src_rd[2]    = wb.s2_rd;
    assign src_wdata[0] = wb.s0_wdata;
    assign src_wdata[1] = wb.s1_wdata;
    assign src_wdata[2] = wb.s2_wdata;

    // Search ptr, ptr+1, ptr+2 (mod 3); the first valid source wins.
    always_comb begin
        grant    = 3'b000;
        gnt_any  = 1'b0;
        gnt_idx  = 2'd0;
        cand_sum = 3'd0;
        cand     = 2'd0;
        for (int i = 0; i < 3; i++) begin
            cand_sum = {1'b0, ptr_q} + 3'(i);
            if (cand_sum >= 3'd3) begin
                cand_sum = cand_sum - 3'd3;
            end
            cand = cand_sum[1:0];
            if (!rst && !gnt_any && src_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign wb.s0_ready = grant[0];
    assign wb.s1_ready = grant[1];
    assign wb.s2_ready = grant[2];

    always_comb begin
        ptr_d      = ptr_q;
        rd_d       = rd_q;
        rd_wdata_d = rd_wdata_q;
        rd_we_d    = 1'b0;
        busy_d     = busy_q;
        if (gnt_any) begin
            ptr_d              = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            rd_d               = src_rd[gnt_idx];
            rd_wdata_d         = src_wdata[gnt_idx];
            rd_we_d            = (src_rd[gnt_idx] != 5'd0);
            busy_d[src_rd[gnt_idx]] = 1'b0;
        end
        // A new long-latency producer is younger than any retiring one.
        if (sb_set && sb_set_rd != 5'd0) begin
            busy_d[sb_set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= 2'd0;
            rd_q       <= 5'd0;
            rd_we_q    <= 1'b0;
            rd_wdata_q <= 32'd0;
            busy_q     <= 32'd0;
        end else begin
            ptr_q      <= ptr_d;
            rd_q       <= rd_d;
            rd_we_q    <= rd_we_d;
            rd_wdata_q <= rd_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign wb.rd       = rd_q;
    assign wb.rd_we    = rd_we_q;
    assign wb.rd_wdata = rd_wdata_q;

    // The registered write is not yet visible in the regfile, so it still counts as busy.
    assign busy_rs1 = (q_rs1 != 5'd0) && (busy_q[q_rs1] || (rd_we_q && rd_q == q_rs1));
    assign busy_rs2 = (q_rs2 != 5'd0) && (busy_q[q_rs2] || (rd_we_q && rd_q == q_rs2));
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        sb_set;
    logic [4:0]  sb_set_rd, q_rs1, q_rs2;
    logic        busy_rs1, busy_rs2;
    logic [2:0]  v;
    logic [4:0]  srd [3];
    logic [31:0] swd [3];
    logic [2:0]  rdy;

    always #5 clk = ~clk;

    rf_wb_arbiter_if wb();

    assign wb.s0_valid = v[0];
    assign wb.s1_valid = v[1];
    assign wb.s2_valid = v[2];
    assign wb.s0_rd    = srd[0];
    assign wb.s1_rd    = srd[1];
    assign wb.s2_rd    = srd[2];
    assign wb.s0_wdata = swd[0];
    assign wb.s1_wdata = swd[1];
    assign wb.s2_wdata = swd[2];
    assign rdy         = {wb.s2_ready, wb.s1_ready, wb.s0_ready};

    rf_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (wb),
        .sb_set   (sb_set),
        .sb_set_rd(sb_set_rd),
        .q_rs1    (q_rs1),
        .q_rs2    (q_rs2),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } out_t;

    out_t        exp_q[$];
    out_t        cur;
    out_t        nxt;
    int          grant_log[$];
    int          mptr;
    logic [31:0] mbusy;
    logic [2:0]  hs;
    logic [2:0]  exp_rdy;
    int          g;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic mb(input logic [4:0] q);
        return (q != 5'd0) && (mbusy[q] || (cur.we && cur.rd == q));
    endfunction

    initial begin
        mptr  = 0;
        mbusy = 32'd0;
        hs    = 3'b000;
        exp_q.push_back('{1'b0, 5'd0, 32'd0});
    end

    // Model: compare this cycle, then predict the state after the next edge.
    always @(negedge clk) begin
        g = -1;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (g < 0 && v[(mptr + i) % 3]) g = (mptr + i) % 3;
            end
        end
        exp_rdy = 3'b000;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", {29'd0, rdy}, {29'd0, exp_rdy});
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else begin
            cur = '{1'b0, 5'd0, 32'd0};
            chk("sb_underflow", 32'd1, 32'd0);
        end
        chk("rd_we", {31'd0, wb.rd_we}, {31'd0, cur.we});
        chk("rd", {27'd0, wb.rd}, {27'd0, cur.rd});
        chk("rd_wdata", wb.rd_wdata, cur.wd);
        chk("busy_rs1", {31'd0, busy_rs1}, {31'd0, mb(q_rs1)});
        chk("busy_rs2", {31'd0, busy_rs2}, {31'd0, mb(q_rs2)});
        hs = 3'b000;
        if (rst) begin
            mptr  = 0;
            mbusy = 32'd0;
            exp_q.push_back('{1'b0, 5'd0, 32'd0});
        end else begin
            nxt    = cur;
            nxt.we = 1'b0;
            if (g >= 0) begin
                mptr         = (g + 1) % 3;
                nxt.rd       = srd[g];
                nxt.wd       = swd[g];
                nxt.we       = (srd[g] != 5'd0);
                mbusy[srd[g]] = 1'b0;
                hs[g]        = 1'b1;
                grant_log.push_back(g);
            end
            if (sb_set && sb_set_rd != 5'd0) mbusy[sb_set_rd] = 1'b1;
            mbusy[0] = 1'b0;
            exp_q.push_back(nxt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_order[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst = 1'b1; v = 3'b000; sb_set = 1'b0; sb_set_rd = 5'd0; q_rs1 = 5'd0; q_rs2 = 5'd0;
        for (int k = 0; k < 3; k++) begin srd[k] = 5'd0; swd[k] = 32'd0; end
        repeat (2) tick();
        rst = 1'b0;

        // single source, then ptr has moved past s0
        v[0] = 1'b1; srd[0] = 5'd5; swd[0] = 32'hDEADBEEF;
        @(negedge clk); chk("t1_s0_ready", {31'd0, wb.s0_ready}, 32'd1);
        tick(); v[0] = 1'b0;
        @(negedge clk);
        chk("t1_rd_we", {31'd0, wb.rd_we}, 32'd1);
        chk("t1_rd", {27'd0, wb.rd}, 32'd5);
        chk("t1_wdata", wb.rd_wdata, 32'hDEADBEEF);
        tick(); v[0] = 1'b1; v[1] = 1'b1; srd[1] = 5'd6; swd[1] = 32'h66;
        @(negedge clk); chk("t1_ptr1_s1", {29'd0, rdy}, 32'b010);
        tick(); v[1] = 1'b0;
        @(negedge clk); chk("t1_then_s0", {29'd0, rdy}, 32'b001);
        tick(); v[0] = 1'b0;

        // all three valid from reset
        rst = 1'b1; tick(); rst = 1'b0;
        grant_log.delete();
        v = 3'b111; srd[0] = 5'd1; srd[1] = 5'd2; srd[2] = 5'd3;
        swd[0] = 32'hA0; swd[1] = 32'hA1; swd[2] = 32'hA2;
        repeat (6) tick();
        v = 3'b000;
        chk("t2_len", grant_log.size(), 32'd6);
        for (int i = 0; i < 6; i++) chk("t2_order", grant_log[i], exp_order[i]);

        // x0 writeback consumed without write enable
        v[1] = 1'b1; srd[1] = 5'd0; swd[1] = 32'h1234; q_rs1 = 5'd0;
        @(negedge clk); chk("t3_s1_ready", {31'd0, wb.s1_ready}, 32'd1);
        tick(); v[1] = 1'b0;
        @(negedge clk);
        chk("t3_rd_we", {31'd0, wb.rd_we}, 32'd0);
        chk("t3_x0_busy", {31'd0, busy_rs1}, 32'd0);

        // scoreboard set, clear via output stage
        tick(); sb_set = 1'b1; sb_set_rd = 5'd7; q_rs1 = 5'd7;
        @(negedge clk); chk("t4_pre", {31'd0, busy_rs1}, 32'd0);
        tick(); sb_set = 1'b0;
        @(negedge clk); chk("t4_set", {31'd0, busy_rs1}, 32'd1);
        tick(); v[2] = 1'b1; srd[2] = 5'd7; swd[2] = 32'h77;
        @(negedge clk); chk("t4_s2_ready", {31'd0, wb.s2_ready}, 32'd1);
        tick(); v[2] = 1'b0;
        @(negedge clk); chk("t4_t1", {31'd0, busy_rs1}, 32'd1);
        tick();
        @(negedge clk); chk("t4_t2", {31'd0, busy_rs1}, 32'd0);

        // set beats clear on the same index
        tick(); sb_set = 1'b1; sb_set_rd = 5'd9; v[1] = 1'b1; srd[1] = 5'd9; swd[1] = 32'h99;
        q_rs1 = 5'd9; q_rs2 = 5'd0;
        @(negedge clk); chk("t5_s1_ready", {31'd0, wb.s1_ready}, 32'd1);
        tick(); sb_set = 1'b0; v[1] = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_busy9", {31'd0, busy_rs1}, 32'd1);
        chk("t5_x0", {31'd0, busy_rs2}, 32'd0);

        // reset mid-stream
        tick(); v = 3'b111; srd[0] = 5'd10; srd[1] = 5'd11; srd[2] = 5'd12;
        tick(); tick(); rst = 1'b1;
        @(negedge clk);
        chk("t6_inflight", {31'd0, wb.rd_we}, 32'd1);
        chk("t6_rst_ready", {29'd0, rdy}, 32'd0);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t6_drop", {31'd0, wb.rd_we}, 32'd0);
        chk("t6_busy_clr", {31'd0, busy_rs1}, 32'd0);
        chk("t6_first_s0", {29'd0, rdy}, 32'b001);
        tick(); v = 3'b000;

        // random traffic: sources hold until their handshake
        for (int n = 0; n < 300; n++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (v[k] && hs[k]) v[k] = 1'b0;
                if (!v[k] && $urandom_range(0, 2) == 0) begin
                    v[k]   = 1'b1;
                    srd[k] = 5'($urandom_range(0, 31));
                    swd[k] = $urandom;
                end
            end
            sb_set    = ($urandom_range(0, 3) == 0);
            sb_set_rd = 5'($urandom_range(0, 31));
            q_rs1     = 5'($urandom_range(0, 31));
            q_rs2     = 5'($urandom_range(0, 31));
            rst       = (n == 150);
        end
        tick(); v = 3'b000; sb_set = 1'b0; rst = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback arbiter and register scoreboard for the RV32IM core's 32×32 register file, which has a single write port. Three writeback sources (ALU, load/store unit, mul/div unit) compete for that port through valid/ready handshakes; the block grants one per cycle round-robin and drives the regfile write port from a registered output stage. It also keeps a 32-entry busy scoreboard so the issue stage can stall on operands whose long-latency producer has not yet written back.

## Interface
- No parameters; source count fixed at 3 (index 0 = ALU, 1 = LSU, 2 = MULDIV).
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- sN_valid  in  1  source N (N=0..2) has a writeback pending
- sN_rd  in  5  destination register of source N
- sN_wdata  in  32  write data of source N
- sN_ready  out  1  source N granted this cycle
- rd  out  5  to regfile write address
- rd_we  out  1  to regfile write enable
- rd_wdata  out  32  to regfile write data
- sb_set  in  1  issue stage dispatched a long-latency op (load, mul, div)
- sb_set_rd  in  5  destination of that op
- q_rs1, q_rs2  in  5  issue-stage operand indices to check
- busy_rs1, busy_rs2  out  1  operand not yet readable from regfile (combinational)

## Operation
- Handshake: transfer on sN_valid && sN_ready. A source holds valid, rd and wdata stable until it sees ready. valid never depends on ready.
- sN_ready is combinational from the valid inputs and the round-robin pointer `ptr` (0..2). Search order is ptr, ptr+1, ptr+2 (mod 3). The first valid source in that order is granted. At most one ready is high per cycle. All ready are 0 while rst=1.
- On a grant to k, at the next edge: `ptr` ← (k+1) mod 3; rd ← sk_rd; rd_wdata ← sk_wdata; rd_we ← (sk_rd != 0). With no grant: rd_we ← 0; rd and rd_wdata hold their values.
- A writeback to x0 is still granted and consumed but never enables the write.
- Scoreboard `busy[31:0]`, bit 0 hardwired 0.
  - sb_set with sb_set_rd != 0 sets busy[sb_set_rd] at the next edge.
  - An accepted transfer from any source clears busy[sk_rd] at the next edge.
  - Set and clear of the same index in the same cycle: set wins, because the new producer is younger.
- busy_rsX = (q_rsX != 0) && (busy[q_rsX] || (rd_we && rd == q_rsX)). The second term covers the cycle in which the write is registered but not yet in the regfile.

## Timing
- Reset values: rd_we=0, rd=0, rd_wdata=0, busy=0, ptr=0, so source 0 has highest priority after reset.
- Grant latency 0: ready is in the same cycle as valid when the source wins. Write-port latency 1: rd_we is high the cycle after the handshake. Data is readable from the regfile 2 cycles after the handshake.
- Throughput is one writeback per cycle. A continuously valid source waits at most 2 cycles.
- rst asserted mid-operation: the in-flight output write is dropped (rd_we=0 next cycle). Pending requests are not granted during the rst cycle and are re-arbitrated from ptr=0 afterward. busy is cleared.
- busy outputs are purely combinational from state and q_rs. There is no q_rs → ready path.

## Test plan
- Reset, then only s0 valid with rd=5, wdata=0xDEADBEEF → s0_ready=1 in the same cycle. The next cycle shows rd_we=1, rd=5, rd_wdata=0xDEADBEEF. ptr ends at 1.
- All three sources held valid for 6 cycles from reset → grant order 0,1,2,0,1,2. rd_we=1 on every cycle from cycle 1 to cycle 6.
- s1 valid with rd=0, wdata=0x1234 → s1_ready=1, and the next cycle rd_we=0. A subsequent read of x0 returns 0.
- sb_set with rd=7 → busy_rs1=1 for q_rs1=7 starting the next cycle. s2 writeback to rd=7 is accepted in cycle T. busy[7] is clear at T+1, but busy_rs1 is still 1 at T+1 via the output stage. busy_rs1=0 at T+2.
- In the same cycle, sb_set rd=9 and an accepted s1 writeback to rd=9 → busy[9]=1 afterward. q_rs2=0 always gives busy_rs2=0.
- rst pulsed for 1 cycle while all sources are valid and rd_we=1 → all ready=0 and rd_we=0 the next cycle, and busy=0. The first grant after reset goes to s0.
